// File: rtl/sprite_mixer.sv
// sprite_mixer: merges prioritised sprite layers through a palette RAM into RGB/de
// with a fixed two-clock latency, and keeps sticky per-frame collision flags.
module sprite_mixer #(
    parameter int          NUM_SPR    = 4,
    parameter int          SPR_DATAW  = 4,
    parameter int          COLRW      = 4,
    parameter int          TRANSP_IDX = 0,
    parameter logic [47:0] BG_COLR    = 48'h000,
    localparam int         WW         = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int         AW         = WW + SPR_DATAW,
    localparam int         RGBW       = 3 * COLRW
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         h_bright,
    input  logic                         v_bright,
    input  logic                         frame_start,
    input  logic [NUM_SPR*SPR_DATAW-1:0] spr_pix,
    input  logic [NUM_SPR-1:0]           spr_drawing,
    input  logic                         pal_we,
    input  logic [AW-1:0]                pal_addr,
    input  logic [RGBW-1:0]              pal_data,
    output logic [NUM_SPR-1:0]           coll_flags,
    output logic [COLRW-1:0]             red,
    output logic [COLRW-1:0]             green,
    output logic [COLRW-1:0]             blue,
    output logic                         de
);
    localparam logic [RGBW-1:0] BG = BG_COLR[RGBW-1:0];

    logic [NUM_SPR-1:0]   opaque;
    logic [WW-1:0]        win;
    logic [SPR_DATAW-1:0] win_pix;
    logic                 hit1_d, de1_d;
    logic [AW-1:0]        rd_addr_d;
    logic [NUM_SPR-1:0]   coll_d;
    logic                 hit1_q, de1_q, hit2_q, de2_q;
    logic [AW-1:0]        rd_addr_q;
    logic [NUM_SPR-1:0]   coll_q;
    logic [RGBW-1:0]      pal_q;
    logic [RGBW-1:0]      mem [2**AW];

    always_comb begin
        opaque  = '0;
        win     = '0;
        win_pix = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            opaque[i] = spr_drawing[i] && spr_pix[i*SPR_DATAW +: SPR_DATAW] != SPR_DATAW'(TRANSP_IDX);
            if (opaque[i]) begin
                win     = WW'(i);
                win_pix = spr_pix[i*SPR_DATAW +: SPR_DATAW];
            end
        end
        de1_d     = h_bright && v_bright;
        hit1_d    = |opaque;
        rd_addr_d = {win, win_pix};
        // two or more opaque layers iff clearing the lowest set bit leaves something
        coll_d    = (frame_start ? '0 : coll_q)
                  | ((de1_d && (opaque & (opaque - NUM_SPR'(1))) != '0) ? opaque : '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit1_q    <= 1'b0;
            de1_q     <= 1'b0;
            rd_addr_q <= '0;
            hit2_q    <= 1'b0;
            de2_q     <= 1'b0;
            coll_q    <= '0;
        end else begin
            hit1_q    <= hit1_d;
            de1_q     <= de1_d;
            rd_addr_q <= rd_addr_d;
            hit2_q    <= hit1_q;
            de2_q     <= de1_q;
            coll_q    <= coll_d;
        end
    end

    // palette is never reset; a same-edge write is not visible to this read
    always_ff @(posedge clk) begin
        if (pal_we) mem[pal_addr] <= pal_data;
        pal_q <= mem[rd_addr_q];
    end

    assign {red, green, blue} = de2_q ? (hit2_q ? pal_q : BG) : '0;
    assign de                 = de2_q;
    assign coll_flags         = coll_q;
endmodule

// File: tb/tb_sprite_mixer.sv
// tb_sprite_mixer: directed stimulus for sprite_mixer, checked every cycle against a
// behavioural model plus hand-computed literal expectations.
module tb_sprite_mixer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        h_bright = 1'b0, v_bright = 1'b0, frame_start = 1'b0;
    logic [15:0] spr_pix = '0;
    logic [3:0]  spr_drawing = '0;
    logic        pal_we = 1'b0;
    logic [5:0]  pal_addr = '0;
    logic [11:0] pal_data = '0;
    logic [3:0]  coll_flags;
    logic [3:0]  red, green, blue;
    logic        de;

    int n_chk = 0;
    int n_fail = 0;
    logic chk_en = 1'b0;

    sprite_mixer dut (
        .clk(clk), .reset(reset), .h_bright(h_bright), .v_bright(v_bright),
        .frame_start(frame_start), .spr_pix(spr_pix), .spr_drawing(spr_drawing),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
        .coll_flags(coll_flags), .red(red), .green(green), .blue(blue), .de(de)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] BG = 12'h000;

    function automatic logic [3:0] opq(input logic [15:0] p, input logic [3:0] d);
        logic [3:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) m[i] = d[i] && (p[i*4 +: 4] != 4'h0);
        return m;
    endfunction

    function automatic logic [5:0] first_addr(input logic [15:0] p, input logic [3:0] d);
        logic [3:0] m;
        m = opq(p, d);
        for (int i = 0; i < 4; i++) if (m[i]) return {2'(i), p[i*4 +: 4]};
        return 6'h00;
    endfunction

    // model: pixel i emerges two edges after it is sampled
    logic [11:0] m_mem [64];
    logic        m_hit1, m_de1, m_de;
    logic [5:0]  m_addr1;
    logic [11:0] m_rgb;
    logic [3:0]  m_flags;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hit1 <= 1'b0; m_de1 <= 1'b0; m_addr1 <= '0;
            m_de <= 1'b0; m_rgb <= '0; m_flags <= '0;
        end else begin
            m_de    <= m_de1;
            m_rgb   <= !m_de1 ? 12'h000 : (m_hit1 ? m_mem[m_addr1] : BG);
            if (pal_we) m_mem[pal_addr] <= pal_data;
            m_hit1  <= opq(spr_pix, spr_drawing) != 4'h0;
            m_addr1 <= first_addr(spr_pix, spr_drawing);
            m_de1   <= h_bright && v_bright;
            m_flags <= (frame_start ? 4'h0 : m_flags)
                     | ((h_bright && v_bright && $countones(opq(spr_pix, spr_drawing)) >= 2)
                        ? opq(spr_pix, spr_drawing) : 4'h0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_chk++;
            if ({red, green, blue} !== m_rgb || de !== m_de || coll_flags !== m_flags) begin
                n_fail++;
                $display("FAIL model t=%0t: rgb=%h de=%b flags=%b, expected rgb=%h de=%b flags=%b",
                         $time, {red, green, blue}, de, coll_flags, m_rgb, m_de, m_flags);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic fs,
                         input logic [15:0] p, input logic [3:0] d);
        h_bright = h; v_bright = v; frame_start = fs; spr_pix = p; spr_drawing = d;
        @(negedge clk);
    endtask

    task automatic pal_write(input logic [5:0] a, input logic [11:0] dat);
        pal_we = 1'b1; pal_addr = a; pal_data = dat;
        @(negedge clk);
        pal_we = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rgb", 16'({red, green, blue}), 16'h000);
        chk("reset_de", 16'(de), 16'h0);
        chk("reset_flags", 16'(coll_flags), 16'h0);
        reset = 1'b1;
        chk_en = 1'b1;
        pal_write(6'h03, 12'hF00);
        pal_write(6'h15, 12'h0F0);
        pal_write(6'h27, 12'h123);
        pal_write(6'h39, 12'h00F);
        @(negedge clk);

        // priority: layer0 beats layer1, both collide
        drive(1, 1, 0, 16'h0053, 4'b0011);
        chk("prio_flags", 16'(coll_flags), 16'h3);
        drive(1, 1, 0, 16'h0000, 4'b0000);
        chk("prio_rgb", 16'({red, green, blue}), 16'hF00);
        chk("prio_de", 16'(de), 16'h1);

        // transparency
        drive(1, 1, 0, 16'h0050, 4'b0011);
        drive(1, 1, 0, 16'h0000, 4'b1111);
        chk("transp_l1", 16'({red, green, blue}), 16'h0F0);
        drive(1, 1, 0, 16'h0053, 4'b0010);
        chk("transp_all_rgb", 16'({red, green, blue}), 16'(BG));
        chk("transp_all_de", 16'(de), 16'h1);
        drive(1, 1, 0, 16'h0000, 4'b0000);
        chk("notdrawing_l0", 16'({red, green, blue}), 16'h0F0);

        // blanking: collision while inactive is ignored
        drive(0, 1, 0, 16'h9700, 4'b1100);
        drive(1, 1, 0, 16'h0000, 4'b0000);
        chk("blank_rgb", 16'({red, green, blue}), 16'h000);
        chk("blank_de", 16'(de), 16'h0);
        chk("blank_flags", 16'(coll_flags), 16'h3);

        // frame clear alone, then re-collide, then clear with new collision
        drive(0, 0, 1, 16'h0000, 4'b0000);
        chk("fs_clear", 16'(coll_flags), 16'h0);
        drive(1, 1, 0, 16'h0053, 4'b0011);
        chk("fs_recollide", 16'(coll_flags), 16'h3);
        drive(1, 1, 1, 16'h9700, 4'b1100);
        chk("fs_newwins", 16'(coll_flags), 16'hC);
        chk("fs_l2_rgb", 16'({red, green, blue}), 16'hF00);
        drive(1, 1, 0, 16'h0000, 4'b0000);
        chk("l2_rgb", 16'({red, green, blue}), 16'h123);

        // palette read-before-write, write during active region
        drive(1, 1, 0, 16'h0700, 4'b0100);
        pal_we = 1'b1; pal_addr = 6'h27; pal_data = 12'hABC;
        drive(1, 1, 0, 16'h0700, 4'b0100);
        pal_we = 1'b0;
        chk("rw_old", 16'({red, green, blue}), 16'h123);
        drive(1, 1, 0, 16'h9000, 4'b1000);
        chk("rw_new", 16'({red, green, blue}), 16'hABC);
        drive(1, 1, 0, 16'h0000, 4'b0000);
        chk("l3_rgb", 16'({red, green, blue}), 16'h00F);

        // async reset mid-line
        h_bright = 1'b1; v_bright = 1'b1; spr_pix = 16'h0053; spr_drawing = 4'b0011;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midreset_de", 16'(de), 16'h0);
        chk("midreset_rgb", 16'({red, green, blue}), 16'h000);
        chk("midreset_flags", 16'(coll_flags), 16'h0);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, 0, 16'h0050, 4'b0010);
        drive(1, 1, 0, 16'h0000, 4'b0000);
        chk("pal_kept", 16'({red, green, blue}), 16'h0F0);
        chk("pal_kept_flags", 16'(coll_flags), 16'h0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
